imem_loader: RTL and testbench

Program loader for the instruction memory of the pipelined core. It receives a framed byte stream containing a length header, little-endian instruction words and an XOR checksum, and writes each assembled word into instruction memory through a one-cycle write strobe. The core is held in reset until a frame has loaded cleanly. It sits between the host/debug byte channel and the instruction-memory write port; the core's fetch path keeps the read side of that memory.

---
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory program loader: parses a length-prefixed, XOR-checksummed
// little-endian byte stream into 32-bit writes and releases the core on success.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state, state_n;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [7:0]  csum;
  logic        acc;
  logic [15:0] n_hdr;
  logic [AW:0] wl_inc;
  logic        last_word;

  assign in_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
  assign acc       = in_valid && in_ready;
  assign n_hdr     = {in_byte, len[7:0]};
  assign wl_inc    = words_loaded + 1'b1;
  assign last_word = (byte_cnt == 2'd3) && (32'(wl_inc) == 32'(len));

  // Status flags are pure state decodes, so they track the state register exactly.
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign cpu_hold = (state != S_DONE);

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = S_LEN_LO;
    end else if (acc) begin
      case (state)
        S_LEN_LO: state_n = S_LEN_HI;
        S_LEN_HI: begin
          if (32'(n_hdr) > 32'(DEPTH)) state_n = S_ERR;
          else if (n_hdr == 16'd0)     state_n = S_CSUM;
          else                         state_n = S_DATA;
        end
        S_DATA:   if (last_word) state_n = S_CSUM;
        S_CSUM:   state_n = (in_byte == csum) ? S_DONE : S_ERR;
        default:  state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len          <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
      csum         <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      state   <= state_n;
      imem_we <= 1'b0;
      if (start) begin
        len          <= '0;
        byte_cnt     <= '0;
        word_buf     <= '0;
        csum         <= '0;
        words_loaded <= '0;
      end else if (acc) begin
        case (state)
          S_LEN_LO: len[7:0]  <= in_byte;
          S_LEN_HI: len[15:8] <= in_byte;
          S_DATA: begin
            csum <= csum ^ in_byte;
            if (byte_cnt == 2'd3) begin
              // words_loaded < DEPTH here, so the truncation to AW bits is exact.
              imem_we      <= 1'b1;
              imem_waddr   <= words_loaded[AW-1:0];
              imem_wdata   <= {in_byte, word_buf};
              words_loaded <= wl_inc;
              byte_cnt     <= 2'd0;
            end else begin
              case (byte_cnt)
                2'd0:    word_buf[7:0]   <= in_byte;
                2'd1:    word_buf[15:8]  <= in_byte;
                default: word_buf[23:16] <= in_byte;
              endcase
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized frames against
// a byte-list model of word packing and XOR checksum.
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready, imem_we, cpu_hold, done, error;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [7:0]    frame_data[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

  always @(negedge clk) if (imem_we) begin
    wa_q.push_back(imem_waddr);
    wd_q.push_back(imem_wdata);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL start_ready got %b want 1", in_ready); else passes++;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    in_valid = 1'b1; in_byte = b;
    t = 0;
    while (!in_ready && t < 20) begin tick(); t++; end
    if (t >= 20) begin
      checks++; $display("FAIL send_timeout in_ready stuck 0 want 1");
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Full frame from frame_data; expectations derived from the byte list.
  task automatic run_frame(input int n, input logic [7:0] cs, input bit gaps, input string tag);
    logic [7:0]  x;
    logic [31:0] w;
    bit          good;
    x = 8'h00;
    foreach (frame_data[i]) x ^= frame_data[i];
    good = (cs == x);
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(n[7:0], gaps);
    send_byte(n[15:8], gaps);
    foreach (frame_data[i]) send_byte(frame_data[i], gaps);
    send_byte(cs, gaps);
    checks++; if (wa_q.size() !== n) $display("FAIL %s nwrites got %0d want %0d", tag, wa_q.size(), n); else passes++;
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      w = {frame_data[4*i+3], frame_data[4*i+2], frame_data[4*i+1], frame_data[4*i]};
      checks++; if (wa_q[i] !== AW'(i)) $display("FAIL %s waddr[%0d] got %0d want %0d", tag, i, wa_q[i], i); else passes++;
      checks++; if (wd_q[i] !== w) $display("FAIL %s wdata[%0d] got %h want %h", tag, i, wd_q[i], w); else passes++;
    end
    checks++; if (done !== good) $display("FAIL %s done got %b want %b", tag, done, good); else passes++;
    checks++; if (error !== !good) $display("FAIL %s error got %b want %b", tag, error, !good); else passes++;
    checks++; if (cpu_hold !== !good) $display("FAIL %s cpu_hold got %b want %b", tag, cpu_hold, !good); else passes++;
    checks++; if (words_loaded !== (AW+1)'(n)) $display("FAIL %s words_loaded got %0d want %0d", tag, words_loaded, n); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL %s in_ready_end got %b want 0", tag, in_ready); else passes++;
  endtask

  task automatic test_reset();
    checks++; if ({in_ready, imem_we, done, error, cpu_hold} !== 5'b00001)
      $display("FAIL reset_flags got %b want 00001", {in_ready, imem_we, done, error, cpu_hold}); else passes++;
    checks++; if ({imem_waddr, imem_wdata, words_loaded} !== '0)
      $display("FAIL reset_bus got %h/%h/%0d want 0", imem_waddr, imem_wdata, words_loaded); else passes++;
  endtask

  task automatic test_two_word();
    frame_data = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hF0, 8'hFF};
    run_frame(2, 8'h13^8'h05^8'hA0^8'h00^8'h93^8'h05^8'hF0^8'hFF, 1'b0, "two_word");
    checks++; if (wd_q.size() != 2 || wd_q[0] !== 32'h00A00513 || wd_q[1] !== 32'hFFF00593)
      $display("FAIL two_word_const got %0d words want 00a00513,fff00593", wd_q.size()); else passes++;
  endtask

  task automatic test_bad_csum();
    frame_data = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hF0, 8'hFF};
    run_frame(2, ~(8'h13^8'h05^8'hA0^8'h00^8'h93^8'h05^8'hF0^8'hFF), 1'b0, "bad_csum");
  endtask

  task automatic test_overflow();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    checks++; if (error !== 1'b1) $display("FAIL ovf_error got %b want 1", error); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL ovf_ready got %b want 0", in_ready); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL ovf_done got %b want 0", done); else passes++;
    in_valid = 1'b1; in_byte = 8'hAA; repeat (4) tick(); in_valid = 1'b0;
    checks++; if (wa_q.size() !== 0) $display("FAIL ovf_writes got %0d want 0", wa_q.size()); else passes++;
    checks++; if (error !== 1'b1) $display("FAIL ovf_hold got %b want 1", error); else passes++;
  endtask

  task automatic test_zero_len();
    frame_data = {};
    run_frame(0, 8'h00, 1'b0, "zero_ok");
    run_frame(0, 8'h01, 1'b0, "zero_bad");
  endtask

  task automatic test_stall_restart();
    logic [7:0] b[5];
    logic [31:0] w;
    foreach (b[i]) b[i] = 8'($urandom);
    w = {b[3], b[2], b[1], b[0]};
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    foreach (b[i]) send_byte(b[i], 1'b1);
    checks++; if (wa_q.size() !== 1 || wd_q[0] !== w)
      $display("FAIL stall_word got %0d writes want 1 of %h", wa_q.size(), w); else passes++;
    checks++; if (words_loaded !== 9'd1) $display("FAIL stall_wl got %0d want 1", words_loaded); else passes++;
    frame_data = {};
    repeat (4) frame_data.push_back(8'($urandom));
    run_frame(1, frame_data[0]^frame_data[1]^frame_data[2]^frame_data[3], 1'b1, "restart");
  endtask

  task automatic test_reset_mid();
    wa_q.delete(); wd_q.delete();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (6) send_byte(8'($urandom), 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_byte = 8'h5A;
    tick();
    rst = 1'b0;
    test_reset();
    repeat (5) tick();
    in_valid = 1'b0;
    checks++; if ({in_ready, done, error, cpu_hold, words_loaded} !== {4'b0001, 9'd0})
      $display("FAIL rst_ignore got %b/%0d want 0001/0", {in_ready, done, error, cpu_hold}, words_loaded); else passes++;
    checks++; if (wa_q.size() !== 1) $display("FAIL rst_writes got %0d want 1", wa_q.size()); else passes++;
  endtask

  task automatic test_random();
    int n;
    logic [7:0] x;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 6);
      frame_data = {};
      x = 8'h00;
      for (int i = 0; i < 4*n; i++) begin
        frame_data.push_back(8'($urandom));
        x ^= frame_data[i];
      end
      if ($urandom_range(0, 2) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      run_frame(n, x, 1'b1, "random");
    end
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_two_word();
    test_bad_csum();
    test_overflow();
    test_zero_len();
    test_stall_restart();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
